// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU operation codes and datapath select codes.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       branch;
        logic       branchNe;
        logic       iorD;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
    } ctl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select and enable.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       branch,
    output logic       branchNe,
    output logic       iorD,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSrc,
    output logic       illegalOp,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   r_is_bne;
    logic   w_rdy;
    ctl_t   w_ctl;

    assign w_rdy = MEM_WAIT_EN ? memReady : 1'b1;

    // The branch flavour is latched in DECODE so BRANCH never looks at the opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_is_bne  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_is_bne <= (opcode == OP_BNE);
                if (!op_supported(opcode))
                    r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   w_next = S_MEMADR;
                    OP_RTYPE:       w_next = S_EXECUTE;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_ADDI:        w_next = S_ADDIEX;
                    OP_J:           w_next = S_JUMP;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = w_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = w_rdy ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_ctl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctl.aluSrcB = SRCB_FOUR;
                w_ctl.aluOp   = ALUOP_ADD;
                w_ctl.pcSrc   = PCSRC_ALU;
                w_ctl.irWrite = w_rdy;
                w_ctl.pcWrite = w_rdy;
            end
            S_DECODE: begin
                w_ctl.aluSrcB = SRCB_IMMSH;
                w_ctl.aluOp   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                w_ctl.aluSrcA = 1'b1;
                w_ctl.aluSrcB = SRCB_IMM;
                w_ctl.aluOp   = ALUOP_ADD;
            end
            S_MEMRD:   w_ctl.iorD = 1'b1;
            S_MEMWB: begin
                w_ctl.memToReg = 1'b1;
                w_ctl.regWrite = 1'b1;
            end
            S_MEMWR: begin
                w_ctl.iorD     = 1'b1;
                w_ctl.memWrite = w_rdy;
            end
            S_EXECUTE: begin
                w_ctl.aluSrcA = 1'b1;
                w_ctl.aluSrcB = SRCB_B;
                w_ctl.aluOp   = ALUOP_RTYPE;
            end
            S_ALUWB: begin
                w_ctl.regDst   = 1'b1;
                w_ctl.regWrite = 1'b1;
            end
            S_BRANCH: begin
                w_ctl.aluSrcA  = 1'b1;
                w_ctl.aluSrcB  = SRCB_B;
                w_ctl.aluOp    = ALUOP_SUB;
                w_ctl.pcSrc    = PCSRC_ALUOUT;
                w_ctl.branch   = !r_is_bne;
                w_ctl.branchNe = r_is_bne;
            end
            S_ADDIWB:  w_ctl.regWrite = 1'b1;
            S_JUMP: begin
                w_ctl.pcSrc   = PCSRC_JUMP;
                w_ctl.pcWrite = 1'b1;
            end
            default: w_ctl = '0;
        endcase
    end

    // Reset kills every write strobe in the same cycle, even mid-instruction.
    assign pcWrite   = w_ctl.pcWrite  & ~reset;
    assign branch    = w_ctl.branch   & ~reset;
    assign branchNe  = w_ctl.branchNe & ~reset;
    assign memWrite  = w_ctl.memWrite & ~reset;
    assign irWrite   = w_ctl.irWrite  & ~reset;
    assign regWrite  = w_ctl.regWrite & ~reset;
    assign iorD      = w_ctl.iorD;
    assign regDst    = w_ctl.regDst;
    assign memToReg  = w_ctl.memToReg;
    assign aluSrcA   = w_ctl.aluSrcA;
    assign aluSrcB   = w_ctl.aluSrcB;
    assign aluOp     = w_ctl.aluOp;
    assign pcSrc     = w_ctl.pcSrc;
    assign illegalOp = r_illegal;
    assign state     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle vector bench for multicycle_control: each row gives the
// inputs for one cycle and the state/control word expected in that cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite, branch, branchNe, iorD, memWrite, irWrite;
    logic       regDst, memToReg, regWrite, aluSrcA, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSrc;
    logic [3:0] state;

    multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .branch(branch), .branchNe(branchNe), .iorD(iorD),
        .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst),
        .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc),
        .illegalOp(illegalOp), .state(state)
    );

    always #5 clk = ~clk;

    // Control word bit order: pcWrite branch branchNe iorD memWrite irWrite
    // regDst memToReg regWrite aluSrcA aluSrcB[1:0] aluOp[1:0] pcSrc[1:0]
    localparam logic [15:0] C_FETCH   = 16'h8410;
    localparam logic [15:0] C_FETCH_S = 16'h0010;
    localparam logic [15:0] C_DECODE  = 16'h0030;
    localparam logic [15:0] C_MEMADR  = 16'h0060;
    localparam logic [15:0] C_MEMRD   = 16'h1000;
    localparam logic [15:0] C_MEMWB   = 16'h0180;
    localparam logic [15:0] C_MEMWR   = 16'h1800;
    localparam logic [15:0] C_MEMWR_S = 16'h1000;
    localparam logic [15:0] C_EXEC    = 16'h0048;
    localparam logic [15:0] C_ALUWB   = 16'h0280;
    localparam logic [15:0] C_BEQ     = 16'h4045;
    localparam logic [15:0] C_BNE     = 16'h2045;
    localparam logic [15:0] C_ADDIEX  = 16'h0060;
    localparam logic [15:0] C_ADDIWB  = 16'h0080;
    localparam logic [15:0] C_JUMP    = 16'h8002;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4,
                           MW = 4'd5, EX = 4'd6, AW = 4'd7, BR = 4'd8, AE = 4'd9,
                           AB = 4'd10, JP = 4'd11;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic rdy,
                                input logic [3:0] st, input logic [15:0] ctl,
                                input logic ill);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.ill = ill;
        return v;
    endfunction

    logic [15:0] act_ctl;

    initial begin
        // reset state (write enables forced low while reset is high)
        vecs.push_back(mk(1, 6'h00, 1, FE, C_FETCH_S, 0));
        // R-type: 4 cycles
        vecs.push_back(mk(0, 6'h00, 1, FE, C_FETCH,  0));
        vecs.push_back(mk(0, 6'h00, 1, DE, C_DECODE, 0));
        vecs.push_back(mk(0, 6'h00, 1, EX, C_EXEC,   0));
        vecs.push_back(mk(0, 6'h00, 1, AW, C_ALUWB,  0));
        // lw with two MEMRD stall cycles: 7 cycles
        vecs.push_back(mk(0, 6'h23, 1, FE, C_FETCH,  0));
        vecs.push_back(mk(0, 6'h23, 1, DE, C_DECODE, 0));
        vecs.push_back(mk(0, 6'h23, 1, MA, C_MEMADR, 0));
        vecs.push_back(mk(0, 6'h23, 0, MR, C_MEMRD,  0));
        vecs.push_back(mk(0, 6'h23, 0, MR, C_MEMRD,  0));
        vecs.push_back(mk(0, 6'h23, 1, MR, C_MEMRD,  0));
        vecs.push_back(mk(0, 6'h23, 1, MB, C_MEMWB,  0));
        // sw with a FETCH stall and a MEMWR stall
        vecs.push_back(mk(0, 6'h2B, 0, FE, C_FETCH_S, 0));
        vecs.push_back(mk(0, 6'h2B, 1, FE, C_FETCH,   0));
        vecs.push_back(mk(0, 6'h2B, 1, DE, C_DECODE,  0));
        vecs.push_back(mk(0, 6'h2B, 1, MA, C_MEMADR,  0));
        vecs.push_back(mk(0, 6'h2B, 0, MW, C_MEMWR_S, 0));
        vecs.push_back(mk(0, 6'h2B, 1, MW, C_MEMWR,   0));
        // beq then bne; bne's opcode changes in BRANCH but must be ignored there
        vecs.push_back(mk(0, 6'h04, 1, FE, C_FETCH,  0));
        vecs.push_back(mk(0, 6'h04, 1, DE, C_DECODE, 0));
        vecs.push_back(mk(0, 6'h04, 1, BR, C_BEQ,    0));
        vecs.push_back(mk(0, 6'h05, 1, FE, C_FETCH,  0));
        vecs.push_back(mk(0, 6'h05, 1, DE, C_DECODE, 0));
        vecs.push_back(mk(0, 6'h04, 1, BR, C_BNE,    0));
        // j
        vecs.push_back(mk(0, 6'h02, 1, FE, C_FETCH,  0));
        vecs.push_back(mk(0, 6'h02, 1, DE, C_DECODE, 0));
        vecs.push_back(mk(0, 6'h02, 1, JP, C_JUMP,   0));
        // illegal opcode, then addi with illegalOp held
        vecs.push_back(mk(0, 6'h3F, 1, FE, C_FETCH,  0));
        vecs.push_back(mk(0, 6'h3F, 1, DE, C_DECODE, 0));
        vecs.push_back(mk(0, 6'h08, 1, FE, C_FETCH,  1));
        vecs.push_back(mk(0, 6'h08, 1, DE, C_DECODE, 1));
        vecs.push_back(mk(0, 6'h08, 1, AE, C_ADDIEX, 1));
        vecs.push_back(mk(0, 6'h08, 1, AB, C_ADDIWB, 1));
        // reset in MEMWR with memReady=1 suppresses memWrite, clears illegalOp
        vecs.push_back(mk(0, 6'h2B, 1, FE, C_FETCH,   1));
        vecs.push_back(mk(0, 6'h2B, 1, DE, C_DECODE,  1));
        vecs.push_back(mk(0, 6'h2B, 1, MA, C_MEMADR,  1));
        vecs.push_back(mk(1, 6'h2B, 1, MW, C_MEMWR_S, 1));
        vecs.push_back(mk(0, 6'h2B, 1, FE, C_FETCH,   0));
        vecs.push_back(mk(0, 6'h2B, 1, DE, C_DECODE,  0));

        reset = 1'b1; opcode = 6'h00; memReady = 1'b1;
        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            opcode   = vecs[i].op;
            memReady = vecs[i].rdy;
            #2;
            act_ctl = {pcWrite, branch, branchNe, iorD, memWrite, irWrite, regDst,
                       memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSrc};
            n_tests++;
            if (state !== vecs[i].st || act_ctl !== vecs[i].ctl ||
                illegalOp !== vecs[i].ill) begin
                n_fail++;
                $display("FAIL vec%0d: state=%0d ctl=%h ill=%b, want state=%0d ctl=%h ill=%b",
                         i, state, act_ctl, illegalOp, vecs[i].st, vecs[i].ctl, vecs[i].ill);
            end
            n_tests++;
            if ((int'(pcWrite) + int'(branch) + int'(branchNe)) > 1 ||
                (regWrite && memWrite)) begin
                n_fail++;
                $display("FAIL excl vec%0d: pcW=%b br=%b bne=%b regW=%b memW=%b, want at most one PC strobe and not regW&memW",
                         i, pcWrite, branch, branchNe, regWrite, memWrite);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
